fpsu_alt_arb: RTL and testbench
===============================

# fpsu_alt_arb

Arbiter and sequencer for the alternate-operand injection port (ALT_INP / ALTDATA0 / ALTDATA1) of the third FP SIMD low-half unit. Two requesters compete for that port: requester 0 is the int-to-FP move path and requester 1 is the FP load-replay path. The block grants at most one injection per cycle, and only into issue slots the scheduler left empty. It tracks each injection to completion, guards against starvation, and sits between the requesters and the low FP SIMD cluster.

## Interface
- LAT, 4: cycles from injection to result on outPlnA/outPlnB; range 1..15.
- STARVE, 8: wait-cycle threshold for the starvation stall; 8-bit counter.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_vld  in  1  requester 0 has an operation
- req0_kind  in  2  ALT_INP code; 0 is illegal
- req0_a, req0_b  in  68 each  operands
- req0_rdy  out  1  grant this cycle (combinational)
- req1_vld, req1_kind, req1_a, req1_b, req1_rdy: same as requester 0
- u5_en  in  4  unit-2 issue enables; any bit set means the slot is occupied
- ALT_INP  out  2  registered injection code to unit 2
- ALTDATA0, ALTDATA1  out  68 each  registered operands
- done_vld  out  1  result valid on outPlnA/outPlnB this cycle
- done_src  out  1  requester owning the result
- alt_stall  out  1  request to the scheduler to leave the next unit-2 slot empty

Clock and reset are fixed: one clock, reset synchronous and active-high.

## Operation
- A request is eligible when its vld=1 and kind≠0. vld with kind=0 is ignored and never granted.
- A grant issues in cycle N only when u5_en==0 at N.
  - One eligible requester: it wins.
  - Both eligible: the round-robin pointer rr wins; rr then flips to the other requester.
  - No grant occurs: rr is unchanged.
- reqX_rdy=1 exactly in the grant cycle. The requester drops or advances its request on that edge.
- Output stage, at N+1: ALT_INP=kind, ALTDATA0=a, ALTDATA1=b for one cycle. Otherwise ALT_INP=0 and the data outputs hold their last values.
- Completion pipe: an LAT-deep shift register of {valid, src}, loaded at grant, shifting every cycle, with no stall. done_vld and done_src come from its last stage.
- Starvation, per requester: the counter increments each cycle the requester is eligible and not granted, and clears on its grant or when it drops eligibility. The counter saturates at 255. alt_stall=1 while either counter ≥ STARVE.
- Reset values: ALT_INP=0, ALTDATA0=0, ALTDATA1=0, done_vld=0, done_src=0, alt_stall=0, rr=0, completion pipe cleared, counters cleared.
- Reset mid-operation: in-flight completions are discarded. Requesters must reissue.

## Timing
- Grant: combinational from reqX_vld, reqX_kind, u5_en and rr in the same cycle.
- Injection visible at N+1.
- done_vld at N+1+LAT.
- Throughput: one injection per cycle when u5_en stays 0.
- Back-to-back grants alternate sources when both requesters hold.
- alt_stall is registered: it rises the cycle after a counter reaches STARVE, and falls the cycle after the grant that clears the counter.
- u5_en≠0 in the same cycle as an eligible request: no grant, no rdy, and the counter advances.

## Configuration
- FPSU_ALT_STARVE_EN defined: starvation counters and alt_stall are built as described.
- FPSU_ALT_STARVE_EN undefined: counters are not built and alt_stall is tied to 0. Arbitration, injection and completion are unchanged.

## Structure
- Shared package fpsu_alt_pkg holds:
  - ALT_INP codes ALT_NONE=0, ALT_MOV=1, ALT_RPL=2, ALT_PAIR=3
  - the 68-bit SIMD half-width constant
  - typedef alt_req_t {vld, kind, a, b}
- One sub-module, fpsu_alt_donepipe: the parameterised LAT-deep {valid, src} shift register.
- Arbitration, the output registers and the starvation counters are inline.

## Test plan
- Reset with req0 held valid: all outputs 0 during rst. After the first clk with rst=0 and u5_en=0: req0_rdy=1 and ALT_INP=req0_kind on the next cycle.
- Both requesters valid for 4 cycles, u5_en=0, rr=0: grants go 0,1,0,1 and ALTDATA0 alternates between req0_a and req1_a.
- req1 valid with kind=1 and u5_en=4'b0010 for 3 cycles, then 0: no rdy for 3 cycles, then rdy, then done_vld=1 with done_src=1 exactly LAT+1 cycles after the grant.
- req0 valid with kind=0: never granted and ALT_INP stays 0.
- STARVE=8 with u5_en busy for 10 cycles against a pending req0: alt_stall rises on cycle 9. After u5_en clears, the grant happens and alt_stall returns to 0 one cycle later. With the macro undefined, alt_stall stays 0.
- rst asserted two cycles after a grant: done_vld never pulses for that grant.

Source files
------------

// File: rtl/fpsu_alt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpsu_alt_pkg
//  Description : Shared definitions for the unit-2 alternate-operand
//                injection arbiter: injection codes, SIMD half width and
//                the requester bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpsu_alt_pkg;

    // Width of one low-half SIMD operand
    localparam int unsigned c_simd_hw = 68;

    // ALT_INP injection codes; ALT_NONE means no injection this cycle
    typedef enum logic [1:0] {
        ALT_NONE = 2'd0,
        ALT_MOV  = 2'd1,
        ALT_RPL  = 2'd2,
        ALT_PAIR = 2'd3
    } alt_code_e;

    // One requester's view of the injection port
    typedef struct packed {
        logic                 vld;
        logic [1:0]           kind;
        logic [c_simd_hw-1:0] a;
        logic [c_simd_hw-1:0] b;
    } alt_req_t;

endpackage
`default_nettype wire

// File: rtl/fpsu_alt_donepipe.sv
`default_nettype none
// ============================================================================
//  Module      : fpsu_alt_donepipe
//  Description : LAT-deep {valid, src} shift register that follows each
//                injection through unit 2 and flags its result cycle.
//                Never stalls; reset discards everything in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpsu_alt_donepipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    input  logic i_src,
    output logic o_vld,
    output logic o_src
);

    logic [LAT-1:0] r_vld;
    logic [LAT-1:0] r_src;

    // Shift one stage per cycle; stage 0 takes the new injection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_src <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_src[0] <= i_src;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_src[i] <= r_src[i-1];
            end
        end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_src = r_src[LAT-1];

endmodule
`default_nettype wire

// File: rtl/fpsu_alt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fpsu_alt_arb
//  Description : Arbiter/sequencer for the unit-2 alternate-operand port.
//                Grants at most one of two requesters per empty issue slot
//                (round-robin on contention), registers the injection,
//                tracks completion LAT cycles later and, when the
//                FPSU_ALT_STARVE_EN macro is defined, raises alt_stall
//                when a requester has waited STARVE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpsu_alt_arb
    import fpsu_alt_pkg::*;
#(
    parameter int LAT    = 4,
    parameter int STARVE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_vld,
    input  logic [1:0]           req0_kind,
    input  logic [c_simd_hw-1:0] req0_a,
    input  logic [c_simd_hw-1:0] req0_b,
    output logic                 req0_rdy,
    input  logic                 req1_vld,
    input  logic [1:0]           req1_kind,
    input  logic [c_simd_hw-1:0] req1_a,
    input  logic [c_simd_hw-1:0] req1_b,
    output logic                 req1_rdy,
    input  logic [3:0]           u5_en,
    output logic [1:0]           ALT_INP,
    output logic [c_simd_hw-1:0] ALTDATA0,
    output logic [c_simd_hw-1:0] ALTDATA1,
    output logic                 done_vld,
    output logic                 done_src,
    output logic                 alt_stall
);

    // Parameter sanity: LAT must fit the 1..15 pipe range, STARVE the 8-bit counter
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("fpsu_alt_arb: LAT out of range 1..15");
    end
    if (STARVE < 1 || STARVE > 255) begin : g_bad_starve
        $error("fpsu_alt_arb: STARVE out of range 1..255");
    end

    alt_req_t             w_req0;
    alt_req_t             w_req1;
    alt_req_t             w_win;
    logic [1:0]           w_elig;
    logic [1:0]           w_gnt;
    logic                 w_slot_free;
    logic                 w_sel;
    logic                 w_inj_vld;
    logic                 r_rr;
    logic [1:0]           r_alt_inp;
    logic [c_simd_hw-1:0] r_data0;
    logic [c_simd_hw-1:0] r_data1;
    logic                 r_inj_src;

    assign w_req0 = '{vld: req0_vld, kind: req0_kind, a: req0_a, b: req0_b};
    assign w_req1 = '{vld: req1_vld, kind: req1_kind, a: req1_a, b: req1_b};

    // A request with code ALT_NONE is never eligible
    assign w_elig[0] = w_req0.vld && (w_req0.kind != ALT_NONE);
    assign w_elig[1] = w_req1.vld && (w_req1.kind != ALT_NONE);

    // Only slots the scheduler left empty can take an injection; nothing is granted in reset
    assign w_slot_free = !rst && (u5_en == 4'd0);

    // Grant: a lone eligible requester wins, contention goes to the rr pointer
    always_comb begin
        w_gnt = 2'b00;
        if (w_slot_free) begin
            if (&w_elig) begin
                w_gnt = r_rr ? 2'b10 : 2'b01;
            end else begin
                w_gnt = w_elig;
            end
        end
    end

    assign w_sel    = w_gnt[1];
    assign w_win    = w_sel ? w_req1 : w_req0;
    assign req0_rdy = w_gnt[0];
    assign req1_rdy = w_gnt[1];

    // Round-robin pointer moves only when a contested grant is made
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_slot_free && (&w_elig)) begin
            r_rr <= ~r_rr;
        end
    end

    // Injection stage: code for one cycle after the grant, operands hold between grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alt_inp <= ALT_NONE;
            r_data0   <= '0;
            r_data1   <= '0;
            r_inj_src <= 1'b0;
        end else if (|w_gnt) begin
            r_alt_inp <= w_win.kind;
            r_data0   <= w_win.a;
            r_data1   <= w_win.b;
            r_inj_src <= w_sel;
        end else begin
            r_alt_inp <= ALT_NONE;
        end
    end

    assign ALT_INP  = r_alt_inp;
    assign ALTDATA0 = r_data0;
    assign ALTDATA1 = r_data1;

    // The pipe starts from the visible injection, so done lands LAT cycles after it
    assign w_inj_vld = (r_alt_inp != ALT_NONE);

    fpsu_alt_donepipe #(
        .LAT (LAT)
    ) u_donepipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_inj_vld),
        .i_src (r_inj_src),
        .o_vld (done_vld),
        .o_src (done_src)
    );

`ifdef FPSU_ALT_STARVE_EN
    localparam logic [7:0] c_starve_thr = 8'(STARVE);

    logic [1:0][7:0] r_cnt;
    logic [1:0][7:0] w_cnt_nxt;
    logic            r_alt_stall;

    // Per requester: count eligible-but-not-granted cycles, saturating at 255
    for (genvar g = 0; g < 2; g++) begin : g_starve
        assign w_cnt_nxt[g] = (w_elig[g] && !w_gnt[g])
                            ? ((r_cnt[g] == 8'hFF) ? r_cnt[g] : r_cnt[g] + 8'd1)
                            : 8'd0;
    end

    // Counters and the stall flag are registered from the same next-count values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_alt_stall <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_alt_stall <= (w_cnt_nxt[0] >= c_starve_thr) || (w_cnt_nxt[1] >= c_starve_thr);
        end
    end

    assign alt_stall = r_alt_stall;
`else
    assign alt_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpsu_alt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpsu_alt_arb
//  Description : Directed self-checking bench for fpsu_alt_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpsu_alt_arb;

    localparam int c_lat    = 4;
    localparam int c_starve = 8;
`ifdef FPSU_ALT_STARVE_EN
    localparam bit c_starve_on = 1'b1;
`else
    localparam bit c_starve_on = 1'b0;
`endif

    localparam logic [67:0] c_a0 = 68'hA_0000_1111_2222_3333;
    localparam logic [67:0] c_b0 = 68'hB_0000_4444_5555_6666;
    localparam logic [67:0] c_a1 = 68'h5_AAAA_0000_BBBB_0001;
    localparam logic [67:0] c_b1 = 68'h6_CCCC_0000_DDDD_0002;
    localparam logic [67:0] c_a2 = 68'h1_2345_6789_ABCD_EF01;
    localparam logic [67:0] c_b2 = 68'hF_EDCB_A987_6543_2101;
    localparam logic [67:0] c_a3 = 68'h7_7777_7777_7777_7777;
    localparam logic [67:0] c_b3 = 68'h8_8888_8888_8888_8888;

    logic        clk;
    logic        rst;
    logic        req0_vld;
    logic [1:0]  req0_kind;
    logic [67:0] req0_a;
    logic [67:0] req0_b;
    logic        req0_rdy;
    logic        req1_vld;
    logic [1:0]  req1_kind;
    logic [67:0] req1_a;
    logic [67:0] req1_b;
    logic        req1_rdy;
    logic [3:0]  u5_en;
    logic [1:0]  ALT_INP;
    logic [67:0] ALTDATA0;
    logic [67:0] ALTDATA1;
    logic        done_vld;
    logic        done_src;
    logic        alt_stall;

    int total = 0;
    int bad   = 0;

    fpsu_alt_arb #(
        .LAT    (c_lat),
        .STARVE (c_starve)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_vld  (req0_vld),
        .req0_kind (req0_kind),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_rdy  (req0_rdy),
        .req1_vld  (req1_vld),
        .req1_kind (req1_kind),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_rdy  (req1_rdy),
        .u5_en     (u5_en),
        .ALT_INP   (ALT_INP),
        .ALTDATA0  (ALTDATA0),
        .ALTDATA1  (ALTDATA1),
        .done_vld  (done_vld),
        .done_src  (done_src),
        .alt_stall (alt_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        u5_en = 4'd0;
        req0_vld = 1'b1; req0_kind = 2'd1; req0_a = c_a0; req0_b = c_b0;
        req1_vld = 1'b0; req1_kind = 2'd0; req1_a = '0;   req1_b = '0;

        // Reset with req0 pending: everything quiet
        tick();
        tick();
        #1;
        chk("rst_rdy0",  req0_rdy,  0);
        chk("rst_alt",   ALT_INP,   0);
        chk("rst_d0",    ALTDATA0,  0);
        chk("rst_d1",    ALTDATA1,  0);
        chk("rst_done",  done_vld,  0);
        chk("rst_src",   done_src,  0);
        chk("rst_stall", alt_stall, 0);

        // First cycle out of reset: req0 granted, injection next cycle
        tick();
        rst = 1'b0;
        #1;
        chk("first_rdy0", req0_rdy, 1);
        chk("first_rdy1", req1_rdy, 0);
        tick();
        chk("first_alt", ALT_INP,  1);
        chk("first_d0",  ALTDATA0, c_a0);
        chk("first_d1",  ALTDATA1, c_b0);
        req0_vld = 1'b0;
        #1;
        chk("first_rdy0_drop", req0_rdy, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("idle_alt", ALT_INP, 0);

        // Both requesters hold for 4 cycles: grants alternate 0,1,0,1
        req0_vld = 1'b1; req0_kind = 2'd1; req0_a = c_a0; req0_b = c_b0;
        req1_vld = 1'b1; req1_kind = 2'd2; req1_a = c_a1; req1_b = c_b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rdy0", req0_rdy, (k % 2 == 0) ? 1 : 0);
            chk("rr_rdy1", req1_rdy, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_alt", ALT_INP,  (k % 2 == 0) ? 68'd1 : 68'd2);
            chk("rr_d0",  ALTDATA0, (k % 2 == 0) ? c_a0 : c_a1);
        end
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // req1 blocked by a busy slot for 3 cycles, then granted; completion tracked
        req1_vld = 1'b1; req1_kind = 2'd1; req1_a = c_a2; req1_b = c_b2;
        u5_en = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_rdy1", req1_rdy, 0);
            tick();
            chk("busy_alt", ALT_INP, 0);
        end
        u5_en = 4'd0;
        #1;
        chk("free_rdy1", req1_rdy, 1);
        tick();
        req1_vld = 1'b0;
        chk("free_alt", ALT_INP,  1);
        chk("free_d1",  ALTDATA1, c_b2);
        // Now in cycle grant+1; done expected at grant+LAT+1
        for (int i = 1; i <= c_lat + 1; i++) begin
            chk("done_vld", done_vld, (i == c_lat + 1) ? 1 : 0);
            if (i == c_lat + 1) chk("done_src", done_src, 1);
            tick();
        end
        chk("done_gone", done_vld, 0);

        // kind=0 is never granted, injection stays empty, data holds
        req0_vld = 1'b1; req0_kind = 2'd0; req0_a = c_a3; req0_b = c_b3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("k0_rdy0", req0_rdy, 0);
            tick();
            chk("k0_alt", ALT_INP,  0);
            chk("k0_d0",  ALTDATA0, c_a2);
        end
        req0_vld = 1'b0;
        tick();

        // Starvation: req0 pending against 10 busy cycles
        req0_vld = 1'b1; req0_kind = 2'd2; req0_a = c_a3; req0_b = c_b3;
        u5_en = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk("stv_stall", alt_stall, (c_starve_on && c >= 9) ? 1 : 0);
            chk("stv_rdy0",  req0_rdy,  0);
            tick();
        end
        // Cycle 11: slot free, grant; stall still up from the previous count
        u5_en = 4'd0;
        #1;
        chk("stv_grant", req0_rdy,  1);
        chk("stv_hold",  alt_stall, c_starve_on ? 1 : 0);
        tick();
        req0_vld = 1'b0;
        chk("stv_alt",   ALT_INP,   2);
        chk("stv_clear", alt_stall, 0);
        for (int i = 0; i < 8; i++) tick();

        // Reset two cycles after a grant: its completion must never appear
        req0_vld = 1'b1; req0_kind = 2'd3; req0_a = c_a0; req0_b = c_b0;
        #1;
        chk("mid_rdy0", req0_rdy, 1);
        tick();
        req0_vld = 1'b0;
        chk("mid_alt", ALT_INP, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_alt", ALT_INP,  0);
        chk("mid_rst_d0",  ALTDATA0, 0);
        for (int i = 0; i < c_lat + 3; i++) begin
            chk("mid_done", done_vld, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
